// File: rtl/stack_driver_if.sv
// Request/response and stack-control bundle for stack_driver.
// master = the driver itself, slave = requester/consumer/stack side.
interface stack_driver_if #(
  parameter int WordSize    = 4,
  parameter int AddressSize = 3
);
  logic                   Req_Valid;
  logic                   Req_Ready;
  logic [1:0]             Req_Op;
  logic [WordSize-1:0]    Req_Data;
  logic                   Rsp_Valid;
  logic                   Rsp_Ready;
  logic [WordSize-1:0]    Rsp_Data;
  logic [1:0]             Rsp_Status;
  logic [AddressSize:0]   Occupancy;
  logic                   Stk_Push;
  logic                   Stk_Pop;
  logic [WordSize-1:0]    Stk_Data_In;
  logic [WordSize-1:0]    Stk_Data_Out;
  logic                   Stk_Full;
  logic                   Stk_Empty;
  logic                   Stk_Error;
  logic                   Mismatch;

  modport master (
    input  Req_Valid, Req_Op, Req_Data, Rsp_Ready,
    input  Stk_Data_Out, Stk_Full, Stk_Empty, Stk_Error,
    output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Status, Occupancy,
    output Stk_Push, Stk_Pop, Stk_Data_In, Mismatch
  );

  modport slave (
    output Req_Valid, Req_Op, Req_Data, Rsp_Ready,
    output Stk_Data_Out, Stk_Full, Stk_Empty, Stk_Error,
    input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Status, Occupancy,
    input  Stk_Push, Stk_Pop, Stk_Data_In, Mismatch
  );
endinterface

// File: rtl/stack_driver.sv
// Single-command front end for the 8-deep LIFO: screens push/pop against Full/Empty,
// strobes the stack for one cycle and returns a held response. Optional: STACK_DRV_SHADOW_CHECK_EN.
module stack_driver #(
  parameter int WordSize    = 4,
  parameter int AddressSize = 3
) (
  input  logic           Clk,
  input  logic           RstN,
  stack_driver_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  localparam logic [1:0] OpPush    = 2'b01;
  localparam logic [1:0] OpPop     = 2'b10;
  localparam logic [1:0] StOk      = 2'b00;
  localparam logic [1:0] StOvf     = 2'b01;
  localparam logic [1:0] StUnf     = 2'b10;
  localparam logic [1:0] StIllegal = 2'b11;
  localparam logic [AddressSize:0] Depth  = {1'b1, {AddressSize{1'b0}}};
  localparam logic [AddressSize:0] OccOne = {{AddressSize{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WordSize-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [AddressSize:0]  occ_q, occ_d;
  logic                  stk_push_q, stk_push_d;
  logic                  stk_pop_q, stk_pop_d;
  logic [WordSize-1:0]   stk_data_in_q, stk_data_in_d;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    occ_d         = occ_q;
    stk_push_d    = 1'b0;
    stk_pop_d     = 1'b0;
    stk_data_in_d = stk_data_in_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.Req_Valid && req_ready_q) begin
          req_ready_d = 1'b0;
          op_d        = bus.Req_Op;
          // Rejected ops go straight to RESP and never touch the stack.
          rsp_valid_d = 1'b1;
          rsp_data_d  = {WordSize{1'b0}};
          state_d     = RESP;
          case (bus.Req_Op)
            OpPush: begin
              if (!bus.Stk_Full) begin
                rsp_valid_d   = 1'b0;
                state_d       = ISSUE;
                stk_push_d    = 1'b1;
                stk_data_in_d = bus.Req_Data;
              end else begin
                rsp_status_d = StOvf;
              end
            end
            OpPop: begin
              if (!bus.Stk_Empty) begin
                rsp_valid_d   = 1'b0;
                state_d       = ISSUE;
                stk_pop_d     = 1'b1;
                stk_data_in_d = bus.Req_Data;
              end else begin
                rsp_status_d = StUnf;
              end
            end
            default: rsp_status_d = StIllegal;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = StOk;
        state_d      = RESP;
        if (op_q == OpPush) begin
          rsp_data_d = {WordSize{1'b0}};
          occ_d      = occ_q + OccOne;
        end else begin
          rsp_data_d = bus.Stk_Data_Out;
          occ_d      = occ_q - OccOne;
        end
      end
      RESP: begin
        if (rsp_valid_q && bus.Rsp_Ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge RstN) begin
    if (RstN) begin
      state_q       <= IDLE;
      op_q          <= 2'b00;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= {WordSize{1'b0}};
      rsp_status_q  <= StOk;
      occ_q         <= {(AddressSize+1){1'b0}};
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= {WordSize{1'b0}};
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      occ_q         <= occ_d;
      stk_push_q    <= stk_push_d;
      stk_pop_q     <= stk_pop_d;
      stk_data_in_q <= stk_data_in_d;
    end
  end

`ifdef STACK_DRV_SHADOW_CHECK_EN
  logic mismatch_q, mismatch_d;

  // The stack acted on the ISSUE edge, so its flags during CAPTURE must match the new count.
  always_comb begin
    mismatch_d = mismatch_q;
    if (state_q == CAPTURE) begin
      if ((bus.Stk_Full != (occ_d == Depth)) ||
          (bus.Stk_Empty != (occ_d == {(AddressSize+1){1'b0}})) ||
          bus.Stk_Error) begin
        mismatch_d = 1'b1;
      end else begin
        mismatch_d = mismatch_q;
      end
    end else begin
      mismatch_d = mismatch_q;
    end
  end

  always_ff @(posedge Clk or posedge RstN) begin
    if (RstN) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign bus.Mismatch = mismatch_q;
`else
  assign bus.Mismatch = 1'b0;
`endif

  assign bus.Req_Ready   = req_ready_q;
  assign bus.Rsp_Valid   = rsp_valid_q;
  assign bus.Rsp_Data    = rsp_data_q;
  assign bus.Rsp_Status  = rsp_status_q;
  assign bus.Occupancy   = occ_q;
  assign bus.Stk_Push    = stk_push_q;
  assign bus.Stk_Pop     = stk_pop_q;
  assign bus.Stk_Data_In = stk_data_in_q;

endmodule

// File: tb/tb_stack_driver.sv
// Directed bench for stack_driver with a behavioural 8-deep LIFO attached to the stack port.
module tb_stack_driver;

  logic clk;
  logic rst;
  logic force_empty;
  int   checks;
  int   errors;
  int   push_pulses;
  int   pop_pulses;
  int   err_seen;

  stack_driver_if #(.WordSize(4), .AddressSize(3)) sd_if ();

  stack_driver #(.WordSize(4), .AddressSize(3)) dut (
    .Clk  (clk),
    .RstN (rst),
    .bus  (sd_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LIFO: popped word is registered, so it is visible the cycle after the pop strobe.
  logic [3:0] mem [8];
  logic [3:0] sp;
  logic [3:0] dout_q;
  logic [3:0] sp_m1;
  assign sp_m1 = sp - 4'd1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp     <= 4'd0;
      dout_q <= 4'd0;
    end else if (sd_if.Stk_Push && !sd_if.Stk_Pop && sp != 4'd8) begin
      mem[sp[2:0]] <= sd_if.Stk_Data_In;
      sp           <= sp + 4'd1;
    end else if (sd_if.Stk_Pop && !sd_if.Stk_Push && sp != 4'd0) begin
      dout_q <= mem[sp_m1[2:0]];
      sp     <= sp_m1;
    end
  end

  assign sd_if.Stk_Data_Out = dout_q;
  assign sd_if.Stk_Full     = (sp == 4'd8);
  assign sd_if.Stk_Empty    = (sp == 4'd0) || force_empty;
  assign sd_if.Stk_Error    = sd_if.Stk_Push && sd_if.Stk_Pop;

  always @(posedge clk) begin
    if (sd_if.Stk_Push)  push_pulses <= push_pulses + 1;
    if (sd_if.Stk_Pop)   pop_pulses  <= pop_pulses + 1;
    if (sd_if.Stk_Error) err_seen    <= err_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request with Rsp_Ready high; checks cycle-exact latency, strobes and response.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] d,
                        input logic [1:0] st, input logic [3:0] rd, input logic [3:0] occ);
    int n;
    int p0;
    int q0;
    logic ok;
    n = 0;
    while (sd_if.Req_Ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready_wait"}, 32'(sd_if.Req_Ready), 32'd1);
    ok = (st == 2'b00);
    p0 = push_pulses;
    q0 = pop_pulses;
    sd_if.Req_Valid = 1'b1;
    sd_if.Req_Op    = op;
    sd_if.Req_Data  = d;
    tick();
    sd_if.Req_Valid = 1'b0;
    chk({tag, "_ready_low"}, 32'(sd_if.Req_Ready), 32'd0);
    if (ok) begin
      chk({tag, "_push_e0"}, 32'(sd_if.Stk_Push), 32'(op == 2'b01));
      chk({tag, "_pop_e0"}, 32'(sd_if.Stk_Pop), 32'(op == 2'b10));
      chk({tag, "_data_in"}, 32'(sd_if.Stk_Data_In), 32'(d));
      chk({tag, "_valid_e0"}, 32'(sd_if.Rsp_Valid), 32'd0);
      tick();
      chk({tag, "_strobes_e1"}, 32'({sd_if.Stk_Push, sd_if.Stk_Pop}), 32'd0);
      chk({tag, "_valid_e1"}, 32'(sd_if.Rsp_Valid), 32'd0);
      tick();
    end else begin
      chk({tag, "_strobes_rej"}, 32'({sd_if.Stk_Push, sd_if.Stk_Pop}), 32'd0);
    end
    chk({tag, "_valid"}, 32'(sd_if.Rsp_Valid), 32'd1);
    chk({tag, "_status"}, 32'(sd_if.Rsp_Status), 32'(st));
    chk({tag, "_rdata"}, 32'(sd_if.Rsp_Data), 32'(rd));
    chk({tag, "_occ"}, 32'(sd_if.Occupancy), 32'(occ));
    tick();
    chk({tag, "_valid_drop"}, 32'(sd_if.Rsp_Valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(sd_if.Req_Ready), 32'd1);
    chk({tag, "_push_pulses"}, 32'(push_pulses - p0), 32'(ok && op == 2'b01));
    chk({tag, "_pop_pulses"}, 32'(pop_pulses - q0), 32'(ok && op == 2'b10));
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    push_pulses     = 0;
    pop_pulses      = 0;
    err_seen        = 0;
    force_empty     = 1'b0;
    rst             = 1'b1;
    sd_if.Req_Valid = 1'b0;
    sd_if.Req_Op    = 2'b00;
    sd_if.Req_Data  = 4'h0;
    sd_if.Rsp_Ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(sd_if.Req_Ready), 32'd0);
    chk("rst_rsp_valid", 32'(sd_if.Rsp_Valid), 32'd0);
    chk("rst_rsp_data", 32'(sd_if.Rsp_Data), 32'd0);
    chk("rst_rsp_status", 32'(sd_if.Rsp_Status), 32'd0);
    chk("rst_occ", 32'(sd_if.Occupancy), 32'd0);
    chk("rst_strobes", 32'({sd_if.Stk_Push, sd_if.Stk_Pop}), 32'd0);
    chk("rst_data_in", 32'(sd_if.Stk_Data_In), 32'd0);
    chk("rst_mismatch", 32'(sd_if.Mismatch), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_before_edge", 32'(sd_if.Req_Ready), 32'd0);
    tick();
    chk("ready_after_edge", 32'(sd_if.Req_Ready), 32'd1);

    run_op("pop_empty", 2'b10, 4'h0, 2'b10, 4'h0, 4'd0);

    run_op("push3", 2'b01, 4'h3, 2'b00, 4'h0, 4'd1);
    run_op("push5", 2'b01, 4'h5, 2'b00, 4'h0, 4'd2);
    run_op("push9", 2'b01, 4'h9, 2'b00, 4'h0, 4'd3);
    run_op("pop9", 2'b10, 4'h0, 2'b00, 4'h9, 4'd2);
    run_op("pop5", 2'b10, 4'h0, 2'b00, 4'h5, 4'd1);
    run_op("pop3", 2'b10, 4'h0, 2'b00, 4'h3, 4'd0);

    run_op("op00", 2'b00, 4'h7, 2'b11, 4'h0, 4'd0);

    // Illegal op with the consumer stalled for five cycles.
    sd_if.Rsp_Ready = 1'b0;
    sd_if.Req_Valid = 1'b1;
    sd_if.Req_Op    = 2'b11;
    sd_if.Req_Data  = 4'hC;
    tick();
    sd_if.Req_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(sd_if.Rsp_Valid), 32'd1);
      chk("stall_status", 32'(sd_if.Rsp_Status), 32'd3);
      chk("stall_ready", 32'(sd_if.Req_Ready), 32'd0);
      tick();
    end
    sd_if.Rsp_Ready = 1'b1;
    chk("stall_still_valid", 32'(sd_if.Rsp_Valid), 32'd1);
    tick();
    chk("stall_released", 32'(sd_if.Rsp_Valid), 32'd0);
    chk("stall_ready_back", 32'(sd_if.Req_Ready), 32'd1);

    for (int i = 1; i <= 8; i++) begin
      run_op("fill", 2'b01, 4'(i), 2'b00, 4'h0, 4'(i));
    end
    run_op("push_full", 2'b01, 4'hF, 2'b01, 4'h0, 4'd8);
    run_op("pop_after_full", 2'b10, 4'h0, 2'b00, 4'h8, 4'd7);

    // Reset while the push strobe is up.
    sd_if.Req_Valid = 1'b1;
    sd_if.Req_Op    = 2'b01;
    sd_if.Req_Data  = 4'hA;
    tick();
    sd_if.Req_Valid = 1'b0;
    chk("midrst_push_up", 32'(sd_if.Stk_Push), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_push_drop", 32'(sd_if.Stk_Push), 32'd0);
    chk("midrst_occ", 32'(sd_if.Occupancy), 32'd0);
    chk("midrst_valid", 32'(sd_if.Rsp_Valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("midrst_no_rsp", 32'(sd_if.Rsp_Valid), 32'd0);
    run_op("midrst_pop", 2'b10, 4'h0, 2'b10, 4'h0, 4'd0);

`ifdef STACK_DRV_SHADOW_CHECK_EN
    run_op("shadow_push1", 2'b01, 4'h1, 2'b00, 4'h0, 4'd1);
    chk("shadow_clean", 32'(sd_if.Mismatch), 32'd0);
    force_empty = 1'b1;
    run_op("shadow_push2", 2'b01, 4'h2, 2'b00, 4'h0, 4'd2);
    chk("shadow_set", 32'(sd_if.Mismatch), 32'd1);
    force_empty = 1'b0;
    run_op("shadow_push3", 2'b01, 4'h3, 2'b00, 4'h0, 4'd3);
    chk("shadow_sticky", 32'(sd_if.Mismatch), 32'd1);
    rst = 1'b1;
    #1;
    chk("shadow_cleared", 32'(sd_if.Mismatch), 32'd0);
    tick();
    rst = 1'b0;
    tick();
`else
    run_op("noshadow_push", 2'b01, 4'h1, 2'b00, 4'h0, 4'd1);
    chk("noshadow_mismatch", 32'(sd_if.Mismatch), 32'd0);
`endif

    chk("stk_error_seen", 32'(err_seen), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_driver.md
# stack_driver

Request/response front end that sits directly upstream of the 8-deep LIFO stack and is the only agent driving its push/pop controls. Accepts single push/pop commands over a valid/ready request channel and issues one-cycle stack strobes. Screens overflow/underflow against the stack's Full/Empty flags, captures popped data, and returns a held response with status. Keeps a shadow occupancy count for software visibility.

## Interface
Parameters:
- WordSize, 4, data width; must match the stack.
- AddressSize, 3, stack depth is 1<<AddressSize; must match the stack.

Ports:
- Clk  in  1  single clock; all state changes on rising edge.
- RstN  in  1  reset, asynchronous, active-high despite the name; same net also drives the stack's reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  driver can accept a request.
- Req_Op  in  2  01 push, 10 pop, 00/11 illegal.
- Req_Data  in  WordSize  push data.
- Rsp_Valid  out  1  response present, held until accepted.
- Rsp_Ready  in  1  consumer accepts response.
- Rsp_Data  out  WordSize  popped word; 0 for push and for rejected ops.
- Rsp_Status  out  2  00 ok, 01 overflow reject, 10 underflow reject, 11 illegal op.
- Occupancy  out  AddressSize+1  shadow count, 0..(1<<AddressSize).
- Stk_Push  out  1  stack push strobe.
- Stk_Pop  out  1  stack pop strobe.
- Stk_Data_In  out  WordSize  data to stack.
- Stk_Data_Out  in  WordSize  stack read data.
- Stk_Full  in  1  stack full flag.
- Stk_Empty  in  1  stack empty flag.
- Stk_Error  in  1  stack simultaneous push/pop flag.
- Mismatch  out  1  sticky shadow/flag disagreement (see Configuration).

## Operation
- Four states: IDLE, ISSUE, CAPTURE, RESP. All outputs registered.
- IDLE: Req_Ready=1. On Req_Valid&Req_Ready, latch op/data and set Req_Ready=0.
  - Push with Stk_Full=0, or pop with Stk_Empty=0: go to ISSUE. Assert Stk_Push or Stk_Pop, and drive Stk_Data_In=Req_Data.
  - Push with Stk_Full=1: go to RESP, status 01.
  - Pop with Stk_Empty=1: go to RESP, status 10.
  - Op 00/11: go to RESP, status 11.
  - The stack is never strobed for any rejected op.
- ISSUE: the strobe is high for exactly this cycle. The stack acts on the closing edge. Go to CAPTURE with strobes cleared.
- CAPTURE: at the closing edge, register Rsp_Data (Stk_Data_Out for pop, 0 for push) and status 00. Update Occupancy (+1 push, −1 pop). Set Rsp_Valid=1. Go to RESP.
- RESP: hold Rsp_Valid/Rsp_Data/Rsp_Status stable until Rsp_Valid&Rsp_Ready. On that edge, clear Rsp_Valid, set Req_Ready=1, and go to IDLE.
- Stk_Push and Stk_Pop are never high together. Stk_Error is therefore never expected; it is observed only under the macro.
- Occupancy arithmetic: AddressSize+1 bits, saturates at neither end. Underflow/overflow are impossible by construction.

## Timing
- Reset (asserted asynchronously): state IDLE, Req_Ready=0, Rsp_Valid=0, Rsp_Data=0, Rsp_Status=00, Occupancy=0, Stk_Push=0, Stk_Pop=0, Stk_Data_In=0, Mismatch=0.
- Req_Ready rises on the first edge after reset release.
- Accept edge E0. Successful op: strobe high during E0..E1, Rsp_Valid high from E2.
- Rejected op: Rsp_Valid high from E0.
- Req_Ready is low from E0 until the response-handshake edge. It is high again in the next cycle.
- Peak throughput: one successful op per 4 cycles with Rsp_Ready tied high.
- Reset mid-operation: any in-flight op is discarded with no response. Strobes drop immediately. The stack is reset by the same net, so Occupancy=0 stays consistent.
- Flags are sampled in IDLE only. They reflect the previous op because that op completed two edges earlier.

## Configuration
- STACK_DRV_SHADOW_CHECK_EN defined: in CAPTURE, Mismatch is set (sticky until reset) if any of the following holds:
  - Stk_Full≠(next Occupancy==1<<AddressSize)
  - Stk_Empty≠(next Occupancy==0)
  - Stk_Error=1
  - The flags are sampled on the edge after CAPTURE.
- Not defined: Mismatch is tied 0 and no comparison logic is built. All other behaviour is identical.

## Test plan
- Reset, then push 0x3, 0x5, 0x9 and pop three times -> pop responses 0x9, 0x5, 0x3 with status 00. Occupancy 3 then 0. Each strobe is exactly 1 cycle.
- Pop on an empty stack after reset -> status 10, Rsp_Data 0, Rsp_Valid in the cycle after accept, no Stk_Pop pulse.
- Push 8 words 0x1..0x8, then push 0xF -> ninth response status 01, Occupancy 8, no Stk_Push. The next pop returns 0x8.
- Req_Op=11 -> status 11. Hold Rsp_Ready=0 for 5 cycles -> Rsp_Valid/Rsp_Status stable and Req_Ready=0 throughout.
- Assert RstN during the ISSUE cycle of a push -> Stk_Push drops immediately, no response, Occupancy 0. A subsequent pop returns status 10.
- With STACK_DRV_SHADOW_CHECK_EN, force Stk_Empty=1 after a successful push -> Mismatch=1 and stays 1 until reset.
